// File: rtl/ebus_diag_seq_pkg.sv
// Shared types and defaults for the EBUS diagnostic transaction sequencer.
// Bit 0 is the MSB of every EBUS-facing vector.
package ebus_diag_seq_pkg;

  typedef logic [0:6]  diag_func_t;
  typedef logic [0:35] ebus_word_t;

  // Functions 100-177 (octal) are reads.
  localparam int unsigned DiagReadBit  = 0;

  localparam int unsigned SetupCycDef  = 2;
  localparam int unsigned StrobeCycDef = 2;
  localparam int unsigned HoldCycDef   = 1;
  localparam int unsigned ReadCycDef   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StSettle,
    StResp
  } diag_seq_state_e;

endpackage

// File: rtl/ebus_diag_seq_if.sv
// Command/response handshake plus EBUS diag lines between the front end and the sequencer.
interface ebus_diag_seq_if;
  import ebus_diag_seq_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  diag_func_t cmd_func;
  ebus_word_t cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  ebus_word_t rsp_rdata;
  logic       rsp_was_read;
  diag_func_t ebus_ds;
  logic       ebus_diag_strobe;
  logic       ebus_driving;
  ebus_word_t ebus_wdata;
  ebus_word_t ebus_rdata;

  modport master (
    output cmd_valid, cmd_func, cmd_wdata, rsp_ready, ebus_rdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_was_read,
    input  ebus_ds, ebus_diag_strobe, ebus_driving, ebus_wdata
  );

  modport slave (
    input  cmd_valid, cmd_func, cmd_wdata, rsp_ready, ebus_rdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_was_read,
    output ebus_ds, ebus_diag_strobe, ebus_driving, ebus_wdata
  );

endinterface

// File: rtl/ebus_diag_seq.sv
// EBUS diagnostic transaction sequencer: turns one diag command into a timed
// setup/strobe/hold write or setup/settle/sample read, with all EBUS outputs registered.
module ebus_diag_seq
  import ebus_diag_seq_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = SetupCycDef,
  parameter int unsigned STROBE_CYC = StrobeCycDef,
  parameter int unsigned HOLD_CYC   = HoldCycDef,
  parameter int unsigned READ_CYC   = ReadCycDef
) (
  input  logic            clk,
  input  logic            rst_n,
  ebus_diag_seq_if.slave  bus_io
);

  localparam logic [7:0] SetupLoad  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] StrobeLoad = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HoldLoad   = (HOLD_CYC == 0) ? 8'd0 : 8'(HOLD_CYC - 1);
  localparam logic [7:0] ReadLoad   = 8'(READ_CYC - 1);

  diag_seq_state_e state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  diag_func_t      func_q, func_d;
  ebus_word_t      wdata_q, wdata_d;
  ebus_word_t      rdata_q, rdata_d;
  logic            was_read_q, was_read_d;

  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  diag_func_t      ds_q, ds_d;
  logic            strobe_q, strobe_d;
  logic            driving_q, driving_d;
  ebus_word_t      ebus_wdata_q, ebus_wdata_d;

  logic            cnt_zero;
  logic            busy_d;

  assign cnt_zero = (cnt_q == 8'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    func_d     = func_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    was_read_d = was_read_q;

    unique case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid) begin
          state_d    = StSetup;
          cnt_d      = SetupLoad;
          func_d     = bus_io.cmd_func;
          wdata_d    = bus_io.cmd_wdata;
          was_read_d = bus_io.cmd_func[DiagReadBit];
          rdata_d    = '0;
        end
      end
      StSetup: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (was_read_q) begin
          state_d = StSettle;
          cnt_d   = ReadLoad;
        end else begin
          state_d = StStrobe;
          cnt_d   = StrobeLoad;
        end
      end
      StStrobe: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else if (HOLD_CYC == 0) begin
          state_d = StResp;
        end else begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end
      end
      StHold: begin
        if (!cnt_zero) cnt_d = cnt_q - 8'd1;
        else           state_d = StResp;
      end
      StSettle: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = StResp;
          rdata_d = bus_io.ebus_rdata;
        end
      end
      StResp: begin
        if (bus_io.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    busy_d       = (state_d == StSetup) || (state_d == StStrobe) ||
                   (state_d == StHold)  || (state_d == StSettle);
    driving_d    = busy_d && (state_d != StSettle) && !was_read_d;
    ds_d         = busy_d ? func_d : '0;
    ebus_wdata_d = driving_d ? wdata_d : '0;
    strobe_d     = (state_d == StStrobe);
    rsp_valid_d  = (state_d == StResp);
    cmd_ready_d  = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      func_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      was_read_q   <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      ds_q         <= '0;
      strobe_q     <= 1'b0;
      driving_q    <= 1'b0;
      ebus_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      func_q       <= func_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      was_read_q   <= was_read_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      ds_q         <= ds_d;
      strobe_q     <= strobe_d;
      driving_q    <= driving_d;
      ebus_wdata_q <= ebus_wdata_d;
    end
  end

  assign bus_io.cmd_ready        = cmd_ready_q;
  assign bus_io.rsp_valid        = rsp_valid_q;
  assign bus_io.rsp_rdata        = rdata_q;
  assign bus_io.rsp_was_read     = was_read_q;
  assign bus_io.ebus_ds          = ds_q;
  assign bus_io.ebus_diag_strobe = strobe_q;
  assign bus_io.ebus_driving     = driving_q;
  assign bus_io.ebus_wdata       = ebus_wdata_q;

endmodule

// File: tb/tb_ebus_diag_seq.sv
// Directed bench for ebus_diag_seq: a vector table of single transactions plus
// hand-written sequences for reset, response hold, back-to-back and zero-hold builds.
module tb_ebus_diag_seq;
  import ebus_diag_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ebus_diag_seq_if bus_a ();
  ebus_diag_seq_if bus_b ();

  ebus_diag_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_a)
  );

  ebus_diag_seq #(
    .HOLD_CYC (0)
  ) dut_h0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus_b)
  );

  typedef struct {
    diag_func_t  func;
    ebus_word_t  wdata;
    ebus_word_t  rdata;
    logic        exp_read;
    int          exp_lat;
    int          exp_strobe;
    int          exp_drive;
    ebus_word_t  exp_rsp;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, strobe_n, drive_n, ds_bad, wd_bad;
    lat = 0; strobe_n = 0; drive_n = 0; ds_bad = 0; wd_bad = 0;
    check("vec_ready_idle", 64'(bus_a.cmd_ready), 64'(1));
    bus_a.cmd_valid  = 1'b1;
    bus_a.cmd_func   = v.func;
    bus_a.cmd_wdata  = v.wdata;
    bus_a.ebus_rdata = v.rdata;
    tick();
    bus_a.cmd_valid = 1'b0;
    while (!bus_a.rsp_valid && lat < 20) begin
      if (bus_a.ebus_ds !== v.func) ds_bad++;
      if (bus_a.ebus_diag_strobe) strobe_n++;
      if (bus_a.ebus_driving) begin
        drive_n++;
        if (bus_a.ebus_wdata !== v.wdata) wd_bad++;
      end else if (bus_a.ebus_wdata !== '0) begin
        wd_bad++;
      end
      tick();
      lat++;
    end
    check("vec_latency", 64'(lat), 64'(v.exp_lat));
    check("vec_strobe_cycles", 64'(strobe_n), 64'(v.exp_strobe));
    check("vec_drive_cycles", 64'(drive_n), 64'(v.exp_drive));
    check("vec_ds_bad", 64'(ds_bad), 64'(0));
    check("vec_wdata_bad", 64'(wd_bad), 64'(0));
    check("vec_rsp_rdata", 64'(bus_a.rsp_rdata), 64'(v.exp_rsp));
    check("vec_was_read", 64'(bus_a.rsp_was_read), 64'(v.exp_read));
    check("vec_resp_ds", 64'(bus_a.ebus_ds), 64'(0));
    check("vec_resp_ready", 64'(bus_a.cmd_ready), 64'(0));
    bus_a.rsp_ready = 1'b1;
    tick();
    bus_a.rsp_ready = 1'b0;
    check("vec_back_idle_ready", 64'(bus_a.cmd_ready), 64'(1));
    check("vec_back_idle_valid", 64'(bus_a.rsp_valid), 64'(0));
  endtask

  initial begin
    int lat, bad, acc, strobes, busy_p;
    logic prev_s, prev_busy, busy;

    vecs[0] = '{7'o042, 36'o123456701234, 36'o666666666666, 1'b0, 5, 2, 5, 36'o0};
    vecs[1] = '{7'o104, 36'o525252525252, 36'o777000111222, 1'b1, 6, 0, 0, 36'o777000111222};
    vecs[2] = '{7'o000, 36'o000000000017, 36'o123123123123, 1'b0, 5, 2, 5, 36'o0};
    vecs[3] = '{7'o177, 36'o0,            36'o000000000001, 1'b1, 6, 0, 0, 36'o000000000001};
    vecs[4] = '{7'o077, 36'o777777777777, 36'o0,            1'b0, 5, 2, 5, 36'o0};

    bus_a.cmd_valid = 1'b0; bus_a.cmd_func = '0; bus_a.cmd_wdata = '0;
    bus_a.rsp_ready = 1'b0; bus_a.ebus_rdata = '0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_func = '0; bus_b.cmd_wdata = '0;
    bus_b.rsp_ready = 1'b0; bus_b.ebus_rdata = '0;

    // Reset values appear without any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_cmd_ready", 64'(bus_a.cmd_ready), 64'(1));
    check("rst_rsp_valid", 64'(bus_a.rsp_valid), 64'(0));
    check("rst_strobe", 64'(bus_a.ebus_diag_strobe), 64'(0));
    check("rst_ds", 64'(bus_a.ebus_ds), 64'(0));
    check("rst_driving", 64'(bus_a.ebus_driving), 64'(0));
    check("rst_rdata", 64'(bus_a.rsp_rdata), 64'(0));
    #10 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      tick();
    end

    // Reset mid-STROBE drops the strobe asynchronously.
    bus_a.cmd_valid = 1'b1; bus_a.cmd_func = 7'o042; bus_a.cmd_wdata = 36'o1;
    tick();
    bus_a.cmd_valid = 1'b0;
    tick();
    tick();
    check("midrst_strobe_before", 64'(bus_a.ebus_diag_strobe), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_strobe_async", 64'(bus_a.ebus_diag_strobe), 64'(0));
    check("midrst_ds_async", 64'(bus_a.ebus_ds), 64'(0));
    #2 rst_n = 1'b1;
    tick();
    check("midrst_cmd_ready", 64'(bus_a.cmd_ready), 64'(1));
    check("midrst_rsp_valid", 64'(bus_a.rsp_valid), 64'(0));
    tick();
    check("midrst_no_rsp", 64'(bus_a.rsp_valid), 64'(0));

    // Read response stays frozen after ebus_rdata moves on.
    bus_a.cmd_valid = 1'b1; bus_a.cmd_func = 7'o101; bus_a.ebus_rdata = 36'o555444333222;
    tick();
    bus_a.cmd_valid = 1'b0;
    lat = 0;
    while (!bus_a.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("hold_latency", 64'(lat), 64'(6));
    bus_a.ebus_rdata = 36'o111111111111;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_a.rsp_rdata !== 36'o555444333222 || !bus_a.rsp_valid) bad++;
    end
    check("hold_rdata_stable", 64'(bad), 64'(0));
    check("hold_rdata_value", 64'(bus_a.rsp_rdata), 64'(36'o555444333222));
    bus_a.rsp_ready = 1'b1;
    tick();
    bus_a.rsp_ready = 1'b0;
    check("hold_released", 64'(bus_a.rsp_valid), 64'(0));
    tick();

    // Three back-to-back writes with cmd_valid and rsp_ready held high.
    bus_a.rsp_ready = 1'b1;
    bus_a.cmd_valid = 1'b1; bus_a.cmd_func = 7'o042; bus_a.cmd_wdata = 36'o7;
    acc = 0; strobes = 0; busy_p = 0; prev_s = 1'b0; prev_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus_a.ebus_diag_strobe && !prev_s) strobes++;
      prev_s = bus_a.ebus_diag_strobe;
      busy = (bus_a.ebus_ds != '0);
      if (busy && !prev_busy) busy_p++;
      prev_busy = busy;
      if (bus_a.cmd_valid && bus_a.cmd_ready) acc++;
      tick();
      if (acc == 3) bus_a.cmd_valid = 1'b0;
    end
    bus_a.rsp_ready = 1'b0;
    check("b2b_accepts", 64'(acc), 64'(3));
    check("b2b_strobe_pulses", 64'(strobes), 64'(3));
    check("b2b_ds_periods", 64'(busy_p), 64'(3));
    check("b2b_end_idle", 64'(bus_a.cmd_ready), 64'(1));

    // Zero-hold build: response directly after the last strobe clock.
    bus_b.cmd_valid = 1'b1; bus_b.cmd_func = 7'o042; bus_b.cmd_wdata = 36'o123456701234;
    tick();
    bus_b.cmd_valid = 1'b0;
    lat = 0; prev_s = 1'b0;
    while (!bus_b.rsp_valid && lat < 20) begin
      prev_s = bus_b.ebus_diag_strobe;
      tick();
      lat++;
    end
    check("h0_latency", 64'(lat), 64'(4));
    check("h0_prev_strobe", 64'(prev_s), 64'(1));
    check("h0_strobe_off", 64'(bus_b.ebus_diag_strobe), 64'(0));
    check("h0_ds_off", 64'(bus_b.ebus_ds), 64'(0));
    check("h0_driving_off", 64'(bus_b.ebus_driving), 64'(0));
    bus_b.rsp_ready = 1'b1;
    tick();
    bus_b.rsp_ready = 1'b0;
    check("h0_idle", 64'(bus_b.cmd_ready), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
